adc_dly_cal: RTL and testbench



---
 rtl/adc_dly_cal.sv | 179 +++++++++++++++++
 tb/tb_adc_dly_cal.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/adc_dly_cal.sv
// IDELAYE2 tap calibration for one ADC lane: sweeps every tap, scores each against a
// training word, then loads the centre of the longest passing window.
module adc_dly_cal #(
  parameter int                TAP_W      = 5,
  parameter int                DATA_W     = 14,
  parameter logic [DATA_W-1:0] PATTERN    = 14'h2AAA,
  parameter int                SETTLE_CYC = 16,
  parameter int                CMP_CNT    = 64
) (
  input  logic              clki,
  input  logic              rsti_n,
  input  logic              start,
  input  logic              dly_rdy,
  input  logic [DATA_W-1:0] adc_data,
  output logic              dly_ld,
  output logic [TAP_W-1:0]  dly_cntvalue,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [TAP_W-1:0]  eye_start,
  output logic [TAP_W:0]    eye_width
);

  localparam int CNT_W = $clog2((CMP_CNT > SETTLE_CYC) ? CMP_CNT : SETTLE_CYC);
  localparam logic [TAP_W-1:0] TAP_MAX = '1;

  typedef enum logic [2:0] {
    ST_IDLE, ST_LOAD, ST_SETTLE, ST_CHECK, ST_EVAL, ST_FINAL
  } state_t;

  state_t             state_reg, state_next;
  logic [TAP_W-1:0]   tap_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic               ok_reg;
  logic [TAP_W:0]     run_len_reg;
  logic [TAP_W-1:0]   run_start_reg;
  logic [TAP_W:0]     best_width_reg;
  logic [TAP_W-1:0]   best_start_reg;
  logic [TAP_W-1:0]   hold_reg;
  logic               done_reg, fail_reg;
  logic [TAP_W-1:0]   eye_start_reg;
  logic [TAP_W:0]     eye_width_reg;

  logic [DATA_W-1:0]  bit_err;
  logic               sample_bad;
  logic               settle_last, check_last;
  logic [TAP_W:0]     close_len;
  logic [TAP_W-1:0]   close_start;
  logic               take_best;
  logic [TAP_W-1:0]   centre_tap, final_tap;

  genvar gi;
  generate
    for (gi = 0; gi < DATA_W; gi++) begin : g_cmp
      assign bit_err[gi] = adc_data[gi] ^ PATTERN[gi];
    end
  endgenerate

  assign sample_bad  = |bit_err;
  assign settle_last = (cnt_reg == CNT_W'(SETTLE_CYC - 1));
  assign check_last  = (cnt_reg == CNT_W'(CMP_CNT - 1));

  // A run is closed on a failing tap, and also on the last tap so a window touching the top is kept.
  always_comb begin
    close_len   = ok_reg ? (run_len_reg + 1'b1) : run_len_reg;
    close_start = (ok_reg && run_len_reg == '0) ? tap_reg : run_start_reg;
    take_best   = (!ok_reg || tap_reg == TAP_MAX) && (close_len > best_width_reg);
  end

  assign centre_tap = best_start_reg + TAP_W'((best_width_reg - 1'b1) >> 1);
  assign final_tap  = (best_width_reg != '0) ? centre_tap : '0;

  always_ff @(posedge clki) begin
    if (!rsti_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (state_reg != ST_IDLE && !dly_rdy) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE:   if (start && dly_rdy) state_next = ST_LOAD;
        ST_LOAD:   state_next = ST_SETTLE;
        ST_SETTLE: if (settle_last) state_next = ST_CHECK;
        ST_CHECK:  if (check_last) state_next = ST_EVAL;
        ST_EVAL:   state_next = (tap_reg == TAP_MAX) ? ST_FINAL : ST_LOAD;
        ST_FINAL:  state_next = ST_IDLE;
        default:   state_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    dly_ld       = 1'b0;
    dly_cntvalue = hold_reg;
    busy         = (state_reg != ST_IDLE);
    case (state_reg)
      ST_LOAD: begin
        dly_ld       = 1'b1;
        dly_cntvalue = tap_reg;
      end
      ST_FINAL: begin
        dly_ld       = 1'b1;
        dly_cntvalue = final_tap;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clki) begin
    if (!rsti_n) begin
      tap_reg        <= '0;
      cnt_reg        <= '0;
      ok_reg         <= 1'b0;
      run_len_reg    <= '0;
      run_start_reg  <= '0;
      best_width_reg <= '0;
      best_start_reg <= '0;
      hold_reg       <= '0;
      done_reg       <= 1'b0;
      fail_reg       <= 1'b0;
      eye_start_reg  <= '0;
      eye_width_reg  <= '0;
    end else if (state_reg == ST_IDLE || dly_rdy) begin
      // Losing dly_rdy mid-sweep freezes everything here; the FSM drops back to idle.
      case (state_reg)
        ST_IDLE: begin
          if (start && dly_rdy) begin
            done_reg       <= 1'b0;
            fail_reg       <= 1'b0;
            run_len_reg    <= '0;
            run_start_reg  <= '0;
            best_width_reg <= '0;
            best_start_reg <= '0;
            tap_reg        <= '0;
          end
        end
        ST_LOAD: begin
          hold_reg <= tap_reg;
          cnt_reg  <= '0;
          ok_reg   <= 1'b1;
        end
        ST_SETTLE: cnt_reg <= settle_last ? '0 : cnt_reg + 1'b1;
        ST_CHECK: begin
          cnt_reg <= check_last ? '0 : cnt_reg + 1'b1;
          if (sample_bad) ok_reg <= 1'b0;
        end
        ST_EVAL: begin
          run_len_reg   <= ok_reg ? close_len : '0;
          run_start_reg <= close_start;
          if (take_best) begin
            best_width_reg <= close_len;
            best_start_reg <= close_start;
          end
          if (tap_reg != TAP_MAX) tap_reg <= tap_reg + 1'b1;
        end
        ST_FINAL: begin
          hold_reg      <= final_tap;
          eye_start_reg <= (best_width_reg != '0) ? best_start_reg : '0;
          eye_width_reg <= best_width_reg;
          done_reg      <= (best_width_reg != '0);
          fail_reg      <= (best_width_reg == '0);
        end
        default: ;
      endcase
    end
  end

  assign done      = done_reg;
  assign fail      = fail_reg;
  assign eye_start = eye_start_reg;
  assign eye_width = eye_width_reg;

endmodule

// File: tb/tb_adc_dly_cal.sv
// Directed bench for adc_dly_cal: an IDELAY/ADC stand-in returns the training word only on
// the taps enabled in each vector's mask; results are checked against hand-computed windows.
`timescale 1ns/1ps
module tb_adc_dly_cal;

  localparam logic [13:0] PAT = 14'h2AAA;

  logic        clki = 1'b0;
  logic        rsti_n, start, dly_rdy;
  logic [13:0] adc_data;
  logic        dly_ld, busy, done, fail;
  logic [4:0]  dly_cntvalue, eye_start;
  logic [5:0]  eye_width;

  int checks = 0;
  int passed = 0;

  adc_dly_cal dut (
    .clki(clki), .rsti_n(rsti_n), .start(start), .dly_rdy(dly_rdy), .adc_data(adc_data),
    .dly_ld(dly_ld), .dly_cntvalue(dly_cntvalue), .busy(busy), .done(done), .fail(fail),
    .eye_start(eye_start), .eye_width(eye_width)
  );

  always #5 clki = ~clki;

  typedef struct {
    logic [31:0] mask;
    int          glitch;
    int          exp_done;
    int          exp_fail;
    int          exp_start;
    int          exp_width;
    int          exp_cnt;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, " dly_ld"}, int'(dly_ld), 0);
    chk({tag, " dly_cntvalue"}, int'(dly_cntvalue), 0);
    chk({tag, " busy"}, int'(busy), 0);
    chk({tag, " done"}, int'(done), 0);
    chk({tag, " fail"}, int'(fail), 0);
    chk({tag, " eye_start"}, int'(eye_start), 0);
    chk({tag, " eye_width"}, int'(eye_width), 0);
  endtask

  // One full sweep; the plant latches dly_cntvalue on dly_ld and answers per the mask.
  task automatic run_vec(input int idx, input vec_t v);
    int n, k, lds, dbl, done_n;
    logic prev_ld, finished;
    logic [4:0] cur_tap;
    n = 0; k = 0; lds = 0; dbl = 0; done_n = 0;
    prev_ld = 1'b0; finished = 1'b0; cur_tap = '0;
    start = 1'b1;
    @(negedge clki);
    start = 1'b0;
    n = 1;
    while (!finished && n < 4000) begin
      if (dly_ld) begin
        lds++;
        if (prev_ld) dbl++;
        cur_tap = dly_cntvalue;
        k = 0;
      end else begin
        k++;
      end
      prev_ld = dly_ld;
      if (n == 2) begin
        chk($sformatf("v%0d cleared done", idx), int'(done), 0);
        chk($sformatf("v%0d busy", idx), int'(busy), 1);
      end
      if (done || fail) begin
        finished = 1'b1;
        done_n = n;
      end
      adc_data = (v.mask[cur_tap] && !(int'(cur_tap) == v.glitch && k == 40)) ? PAT : ~PAT;
      start = (n == 1000);
      if (!finished) begin
        @(negedge clki);
        n++;
      end
    end
    start = 1'b0;
    chk($sformatf("v%0d finished", idx), int'(finished), 1);
    chk($sformatf("v%0d done", idx), int'(done), v.exp_done);
    chk($sformatf("v%0d fail", idx), int'(fail), v.exp_fail);
    chk($sformatf("v%0d eye_start", idx), int'(eye_start), v.exp_start);
    chk($sformatf("v%0d eye_width", idx), int'(eye_width), v.exp_width);
    chk($sformatf("v%0d dly_cntvalue", idx), int'(dly_cntvalue), v.exp_cnt);
    chk($sformatf("v%0d result cycle", idx), done_n, 2626);
    chk($sformatf("v%0d ld pulses", idx), lds, 33);
    chk($sformatf("v%0d back-to-back ld", idx), dbl, 0);
    chk($sformatf("v%0d busy after", idx), int'(busy), 0);
    $display("vector %0d: mask=%08h done=%0d fail=%0d eye_start=%0d eye_width=%0d tap=%0d at cycle %0d",
             idx, v.mask, done, fail, eye_start, eye_width, dly_cntvalue, done_n);
  endtask

  initial begin
    int lds;
    vecs[0] = '{32'hFFFF_FFFF, -1, 1, 0, 0, 32, 15};
    vecs[1] = '{32'h001F_FC00, -1, 1, 0, 10, 11, 15};
    vecs[2] = '{32'h001F_F03C, -1, 1, 0, 12, 9, 16};
    vecs[3] = '{32'h00F0_0078, -1, 1, 0, 3, 4, 4};
    vecs[4] = '{32'h0000_0000, -1, 0, 1, 0, 0, 0};
    vecs[5] = '{32'h0000_1FE0, 8, 1, 0, 9, 4, 10};
    vecs[6] = '{32'hFE00_0007, -1, 1, 0, 25, 7, 28};
    vecs[7] = '{32'h0000_0001, -1, 1, 0, 0, 1, 0};

    rsti_n = 1'b0; start = 1'b0; dly_rdy = 1'b1; adc_data = PAT;
    repeat (3) @(negedge clki);
    check_idle_outputs("reset");
    rsti_n = 1'b1;
    @(negedge clki);

    for (int i = 0; i < 8; i++) begin
      run_vec(i, vecs[i]);
      @(negedge clki);
    end

    // Abort: dly_rdy drops in cycle 500, during tap 6.
    adc_data = PAT;
    start = 1'b1;
    @(negedge clki);
    start = 1'b0;
    repeat (499) @(negedge clki);
    chk("abort pre busy", int'(busy), 1);
    chk("abort pre tap", int'(dly_cntvalue), 6);
    dly_rdy = 1'b0;
    @(negedge clki);
    chk("abort busy", int'(busy), 0);
    chk("abort done", int'(done), 0);
    chk("abort fail", int'(fail), 0);
    chk("abort tap kept", int'(dly_cntvalue), 6);
    lds = 0;
    for (int c = 0; c < 100; c++) begin
      if (dly_ld) lds++;
      @(negedge clki);
    end
    chk("abort no ld", lds, 0);
    chk("abort stays idle", int'(busy), 0);
    $display("abort: busy=%0d done=%0d fail=%0d tap=%0d", busy, done, fail, dly_cntvalue);

    // start with dly_rdy low must not leave idle.
    start = 1'b1;
    repeat (5) @(negedge clki);
    chk("rdy low busy", int'(busy), 0);
    chk("rdy low ld", int'(dly_ld), 0);
    start = 1'b0;
    dly_rdy = 1'b1;
    $display("start without rdy: busy=%0d", busy);
    @(negedge clki);

    // Full run to populate eye outputs, then reset mid-way through a second sweep.
    run_vec(8, vecs[1]);
    @(negedge clki);
    start = 1'b1;
    @(negedge clki);
    start = 1'b0;
    repeat (999) @(negedge clki);
    chk("rst pre tap", int'(dly_cntvalue), 12);
    chk("rst pre eye_start", int'(eye_start), 10);
    rsti_n = 1'b0;
    @(negedge clki);
    check_idle_outputs("mid reset");
    rsti_n = 1'b1;
    $display("mid-sweep reset: busy=%0d tap=%0d eye_width=%0d", busy, dly_cntvalue, eye_width);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
